// File: rtl/crg_pkg.sv
// rtl/crg_pkg.sv - shared clock/reset generator types and defaults
package crg_pkg;

    typedef enum logic [1:0] {
        CG_OFF   = 2'd0,
        CG_WAKE  = 2'd1,
        CG_ON    = 2'd2,
        CG_DRAIN = 2'd3
    } cg_state_e;

    localparam int CG_WAKE_DELAY_DEF  = 2;
    localparam int CG_IDLE_CYCLES_DEF = 16;

    function automatic int cg_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - REQ/ACK enable controller for the DFF_CG gating cell
module clk_gate_ctrl
    import crg_pkg::*;
#(
    parameter int WAKE_DELAY  = CG_WAKE_DELAY_DEF,
    parameter int IDLE_CYCLES = CG_IDLE_CYCLES_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req,
    input  logic       i_busy,
    input  logic       i_force_on,
    output logic       o_en,
    output logic       o_ack,
    output logic [1:0] o_state
);

    localparam int CNT_W = $clog2(cg_max(WAKE_DELAY, IDLE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] WAKE_LD  = CNT_W'(WAKE_DELAY);
    localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'(IDLE_CYCLES);

    cg_state_e        r_state;
    cg_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_en;
    logic             r_ack;

    // One down-counter serves both the wake latency and the idle window.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            CG_OFF: begin
                if (i_req || i_force_on) begin
                    w_state_nxt = CG_WAKE;
                    w_cnt_nxt   = WAKE_LD;
                end
            end
            CG_WAKE: begin
                if (r_cnt == CNT_ONE) begin
                    if (i_req) begin
                        w_state_nxt = CG_ON;
                    end else begin
                        w_state_nxt = CG_DRAIN;
                        w_cnt_nxt   = IDLE_LD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            CG_ON: begin
                if (!i_req) begin
                    w_state_nxt = CG_DRAIN;
                    w_cnt_nxt   = IDLE_LD;
                end
            end
            CG_DRAIN: begin
                // Clock is still running here, so a new request skips the wake delay.
                if (i_req) begin
                    w_state_nxt = CG_ON;
                end else if (i_busy || i_force_on) begin
                    w_cnt_nxt = IDLE_LD;
                end else if (r_cnt == CNT_ONE) begin
                    w_state_nxt = CG_OFF;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = CG_OFF;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= CG_OFF;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_en    <= (w_state_nxt != CG_OFF);
            r_ack   <= (w_state_nxt == CG_ON);
        end
    end

    assign o_en    = r_en;
    assign o_ack   = r_ack;
    assign o_state = r_state;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - scoreboard bench for clk_gate_ctrl with default parameters
module tb_clk_gate_ctrl;

    logic       clk;
    logic       rst;
    logic       req;
    logic       busy;
    logic       force_on;
    logic       en;
    logic       ack;
    logic [1:0] state;

    clk_gate_ctrl dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_busy     (busy),
        .i_force_on (force_on),
        .o_en       (en),
        .o_ack      (ack),
        .o_state    (state)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic       en;
        logic       ack;
        logic [1:0] st;
    } chk_t;

    chk_t q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter: cyc==k between posedge k and posedge k+1.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            chk_t c;
            c = q.pop_front();
            n_tests++;
            if (c.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: check for edge %0d missed (now edge %0d)", c.name, c.cyc, cyc);
            end else if (en !== c.en || ack !== c.ack || state !== c.st) begin
                n_fail++;
                $display("FAIL %s @edge %0d: got en=%b ack=%b state=%0d, expected en=%b ack=%b state=%0d",
                         c.name, cyc, en, ack, state, c.en, c.ack, c.st);
            end
        end
    end

    task automatic expect_at(input int k, input string name,
                             input logic e, input logic a, input logic [1:0] s);
        chk_t c;
        c.cyc = k; c.name = name; c.en = e; c.ack = a; c.st = s;
        q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int k);
        int guard = 0;
        while (cyc < k && guard < 1000) begin
            tick();
            guard++;
        end
    endtask

    int b;

    initial begin
        rst = 1'b1; req = 1'b0; busy = 1'b0; force_on = 1'b0;
        run_to(2);
        rst = 1'b0;
        b = cyc;
        expect_at(b, "reset_state", 1'b0, 1'b0, 2'd0);

        // Wake and release with defaults
        expect_at(b+5,  "wake_pre",   1'b0, 1'b0, 2'd0);
        expect_at(b+6,  "wake_en",    1'b1, 1'b0, 2'd1);
        expect_at(b+7,  "wake_hold",  1'b1, 1'b0, 2'd1);
        expect_at(b+8,  "wake_ack",   1'b1, 1'b1, 2'd2);
        expect_at(b+20, "on_steady",  1'b1, 1'b1, 2'd2);
        expect_at(b+21, "rel_ack0",   1'b1, 1'b0, 2'd3);
        expect_at(b+36, "drain_last", 1'b1, 1'b0, 2'd3);
        expect_at(b+37, "drain_off",  1'b0, 1'b0, 2'd0);
        run_to(b+5);  req = 1'b1;
        run_to(b+20); req = 1'b0;

        // BUSY pulse in DRAIN reloads the idle window
        b = b + 40;
        expect_at(b+8,  "busy_on",     1'b1, 1'b1, 2'd2);
        expect_at(b+21, "busy_drain",  1'b1, 1'b0, 2'd3);
        expect_at(b+37, "busy_held",   1'b1, 1'b0, 2'd3);
        expect_at(b+46, "busy_last",   1'b1, 1'b0, 2'd3);
        expect_at(b+47, "busy_off",    1'b0, 1'b0, 2'd0);
        run_to(b+5);  req = 1'b1;
        run_to(b+20); req = 1'b0;
        run_to(b+30); busy = 1'b1;
        run_to(b+31); busy = 1'b0;

        // Re-request in DRAIN, with simultaneous BUSY: REQ wins, no WAKE
        b = b + 50;
        expect_at(b+21, "rereq_drain", 1'b1, 1'b0, 2'd3);
        expect_at(b+25, "rereq_pre",   1'b1, 1'b0, 2'd3);
        expect_at(b+26, "rereq_ack",   1'b1, 1'b1, 2'd2);
        expect_at(b+31, "rereq_rel",   1'b1, 1'b0, 2'd3);
        expect_at(b+47, "rereq_off",   1'b0, 1'b0, 2'd0);
        run_to(b+5);  req = 1'b1;
        run_to(b+20); req = 1'b0;
        run_to(b+25); req = 1'b1; busy = 1'b1;
        run_to(b+26); busy = 1'b0;
        run_to(b+30); req = 1'b0;

        // FORCE_ON from OFF: wake then held DRAIN, never ACK
        b = b + 50;
        expect_at(b+2,  "force_wake",  1'b1, 1'b0, 2'd1);
        expect_at(b+3,  "force_wake2", 1'b1, 1'b0, 2'd1);
        expect_at(b+4,  "force_drain", 1'b1, 1'b0, 2'd3);
        expect_at(b+40, "force_held",  1'b1, 1'b0, 2'd3);
        expect_at(b+65, "force_last",  1'b1, 1'b0, 2'd3);
        expect_at(b+66, "force_off",   1'b0, 1'b0, 2'd0);
        run_to(b+1);  force_on = 1'b1;
        run_to(b+50); force_on = 1'b0;

        // Async reset mid-WAKE and mid-ON with REQ held high
        b = b + 70;
        expect_at(b+2, "rst_pre_wake", 1'b1, 1'b0, 2'd1);
        run_to(b+1); req = 1'b1;
        run_to(b+3); rst = 1'b1;
        expect_at(b+3,  "rst_wake_now",  1'b0, 1'b0, 2'd0);
        expect_at(b+4,  "rst_wake_hold", 1'b0, 1'b0, 2'd0);
        expect_at(b+6,  "rst_rewake",    1'b1, 1'b0, 2'd1);
        expect_at(b+8,  "rst_reack",     1'b1, 1'b1, 2'd2);
        run_to(b+5); rst = 1'b0;
        run_to(b+12); rst = 1'b1;
        expect_at(b+12, "rst_on_now",    1'b0, 1'b0, 2'd0);
        expect_at(b+14, "rst_on_rewake", 1'b1, 1'b0, 2'd1);
        expect_at(b+16, "rst_on_reack",  1'b1, 1'b1, 2'd2);
        run_to(b+13); rst = 1'b0;
        run_to(b+20); req = 1'b0;
        run_to(b+24);

        #6;
        while (q.size() > 0) begin
            chk_t c;
            c = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: check for edge %0d never reached", c.name, c.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
